load_store_unit: RTL

Sub-word access engine between the single-cycle datapath's load/store decode and the word-addressed data memory (`memoria`). Converts byte/halfword/word load and store requests into 32-bit word memory accesses: lane extraction plus sign/zero extension for loads, read-modify-write for sub-word stores. Alignment is checked on every request. A `busy` stall output tells the datapath to hold its request while a multi-cycle access is in flight.

---
 rtl/load_store_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Sub-word access engine between the datapath load/store decode
//             and a word-addressed data memory. Byte/halfword loads are lane
//             extracted and sign/zero extended; byte/halfword stores are done
//             as a read-modify-write of the containing word. Misaligned and
//             illegal-size requests complete with an error and no memory
//             access.
//  Ports    : clock, rst          - clock, synchronous active-high reset
//             req_*               - request (sampled only on the accept edge)
//             busy                - stall: high whenever the FSM is not IDLE
//             resp_valid/err/rdata- registered one-cycle completion
//             mem_*               - word memory port (combinational read,
//                                   write committed on the rising edge)
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_writeData,
    input  logic [31:0]       mem_readData,
    output logic              mem_memWrite,
    output logic              mem_memRead
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;
    localparam logic [1:0] c_SIZE_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_STORE_W = 3'd2,
        S_RMW_RD  = 3'd3,
        S_RMW_WR  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Request fields latched at the accept edge. The access direction is
    // carried by the FSM state itself, so it needs no separate register.
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [31:0]         r_wdata;
    logic [31:0]         r_merged;

    logic                r_resp_valid;
    logic                r_resp_err;
    logic [31:0]         r_resp_rdata;

    logic                w_bad_req;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merged;
    logic                w_rd;
    logic                w_wr;
    logic [31:0]         w_wdata;

    // Alignment / legality check on the live request (used only in IDLE)
    always_comb begin
        w_bad_req = 1'b0;
        if (req_size == c_SIZE_ILL) begin
            w_bad_req = 1'b1;
        end else if (req_size == c_SIZE_HALF && req_addr[0]) begin
            w_bad_req = 1'b1;
        end else if (req_size == c_SIZE_WORD && req_addr[1:0] != 2'b00) begin
            w_bad_req = 1'b1;
        end
    end

    // Little-endian lane extraction for loads
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_readData[7:0];
            2'd1:    w_byte = mem_readData[15:8];
            2'd2:    w_byte = mem_readData[23:16];
            default: w_byte = mem_readData[31:24];
        endcase
        w_half = r_addr[1] ? mem_readData[31:16] : mem_readData[15:0];
        case (r_size)
            c_SIZE_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default:     w_load_data = mem_readData;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane
    always_comb begin
        w_merged = mem_readData;
        if (r_size == c_SIZE_BYTE) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    // Next-state and memory-strobe decode
    always_comb begin
        w_next_state = r_state;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        w_wdata      = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && !w_bad_req) begin
                    if (!req_write) begin
                        w_next_state = S_LOAD;
                    end else if (req_size == c_SIZE_WORD) begin
                        w_next_state = S_STORE_W;
                    end else begin
                        w_next_state = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                w_rd         = 1'b1;
                w_next_state = S_IDLE;
            end
            S_STORE_W: begin
                w_wr         = 1'b1;
                w_wdata      = r_wdata;
                w_next_state = S_IDLE;
            end
            S_RMW_RD: begin
                w_rd         = 1'b1;
                w_next_state = S_RMW_WR;
            end
            S_RMW_WR: begin
                w_wr         = 1'b1;
                w_wdata      = r_merged;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_wdata      <= 32'd0;
            r_merged     <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= req_addr;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_wdata  <= req_wdata;
                        if (w_bad_req) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
                S_STORE_W: begin
                    r_resp_valid <= 1'b1;
                end
                S_RMW_RD: begin
                    r_merged <= w_merged;
                end
                S_RMW_WR: begin
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_err      = r_resp_err;
    assign resp_rdata    = r_resp_rdata;
    assign mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_writeData = w_wdata;
    // Strobes are gated by reset so an interrupted access never touches memory
    assign mem_memWrite  = w_wr & ~rst;
    assign mem_memRead   = w_rd & ~rst;

endmodule
`default_nettype wire
